// File: rtl/frame_minmax_tracker.sv
// Running max/min/count tracker over valid/ready sample frames; result held until accepted.
// Optional MINMAX_INDEX_EN adds max_idx/min_idx (zero-based position of first extreme).
module frame_minmax_tracker #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   in_data,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH-1:0]                   max,
  output logic [WIDTH-1:0]                   min,
`ifdef MINMAX_INDEX_EN
  output logic [((FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1)-1:0] max_idx,
  output logic [((FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1)-1:0] min_idx,
`endif
  output logic [$clog2(FRAME_LEN+1)-1:0]     count
);

  localparam int unsigned CW = $clog2(FRAME_LEN + 1);
  localparam int unsigned IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state, state_n;
  logic             first, first_n;
  logic [WIDTH-1:0] run_max, run_max_n, run_min, run_min_n;
  logic [CW-1:0]    run_cnt, run_cnt_n;
  logic             in_ready_n, out_valid_n;
  logic [WIDTH-1:0] max_n, min_n;
  logic [CW-1:0]    count_n;
  logic             accept, close;
  logic [WIDTH-1:0] cur_max, cur_min;
  logic [CW-1:0]    cur_cnt;
`ifdef MINMAX_INDEX_EN
  logic [IW-1:0]    run_max_idx, run_max_idx_n, run_min_idx, run_min_idx_n;
  logic [IW-1:0]    cur_max_idx, cur_min_idx;
  logic [IW-1:0]    max_idx_n, min_idx_n;
`endif

  // Accumulators as they stand including the sample on the input this cycle
  always_comb begin
    accept  = in_valid && (state == ACCUM);
    cur_max = (first || (in_data > run_max)) ? in_data : run_max;
    cur_min = (first || (in_data < run_min)) ? in_data : run_min;
    cur_cnt = first ? CW'(1) : run_cnt + CW'(1);
    close   = accept && (in_last || (cur_cnt == CW'(FRAME_LEN)));
`ifdef MINMAX_INDEX_EN
    cur_max_idx = (first || (in_data > run_max)) ? IW'(run_cnt) : run_max_idx;
    cur_min_idx = (first || (in_data < run_min)) ? IW'(run_cnt) : run_min_idx;
`endif
  end

  // Next-state and output decode
  always_comb begin
    state_n     = state;
    first_n     = first;
    run_max_n   = run_max;
    run_min_n   = run_min;
    run_cnt_n   = run_cnt;
    out_valid_n = out_valid;
    max_n       = max;
    min_n       = min;
    count_n     = count;
`ifdef MINMAX_INDEX_EN
    run_max_idx_n = run_max_idx;
    run_min_idx_n = run_min_idx;
    max_idx_n     = max_idx;
    min_idx_n     = min_idx;
`endif
    case (state)
      ACCUM: begin
        if (accept) begin
          first_n   = 1'b0;
          run_max_n = cur_max;
          run_min_n = cur_min;
          run_cnt_n = cur_cnt;
`ifdef MINMAX_INDEX_EN
          run_max_idx_n = cur_max_idx;
          run_min_idx_n = cur_min_idx;
`endif
          if (close) begin
            max_n       = cur_max;
            min_n       = cur_min;
            count_n     = cur_cnt;
            out_valid_n = 1'b1;
            state_n     = HOLD;
`ifdef MINMAX_INDEX_EN
            max_idx_n = cur_max_idx;
            min_idx_n = cur_min_idx;
`endif
          end
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          out_valid_n = 1'b0;
          first_n     = 1'b1;
          run_max_n   = '0;
          run_min_n   = '0;
          run_cnt_n   = '0;
          state_n     = ACCUM;
`ifdef MINMAX_INDEX_EN
          run_max_idx_n = '0;
          run_min_idx_n = '0;
`endif
        end
      end
      default: state_n = ACCUM;
    endcase
    in_ready_n = (state_n == ACCUM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      first     <= 1'b1;
      run_max   <= '0;
      run_min   <= '0;
      run_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      max       <= '0;
      min       <= '0;
      count     <= '0;
`ifdef MINMAX_INDEX_EN
      run_max_idx <= '0;
      run_min_idx <= '0;
      max_idx     <= '0;
      min_idx     <= '0;
`endif
    end else begin
      state     <= state_n;
      first     <= first_n;
      run_max   <= run_max_n;
      run_min   <= run_min_n;
      run_cnt   <= run_cnt_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      max       <= max_n;
      min       <= min_n;
      count     <= count_n;
`ifdef MINMAX_INDEX_EN
      run_max_idx <= run_max_idx_n;
      run_min_idx <= run_min_idx_n;
      max_idx     <= max_idx_n;
      min_idx     <= min_idx_n;
`endif
    end
  end

endmodule

// File: tb/tb_frame_minmax_tracker.sv
// Self-checking bench for frame_minmax_tracker: queue-based frame model checked every cycle,
// plus directed frames with literal expectations.
module tb_frame_minmax_tracker;

  localparam int unsigned WIDTH     = 4;
  localparam int unsigned FRAME_LEN = 8;
  localparam int unsigned CW        = $clog2(FRAME_LEN + 1);
  localparam int unsigned IW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] max, min;
  logic [CW-1:0]    count;
`ifdef MINMAX_INDEX_EN
  logic [IW-1:0]    max_idx, min_idx;
`endif

  int checks = 0;
  int errors = 0;

  frame_minmax_tracker #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .max(max), .min(min),
`ifdef MINMAX_INDEX_EN
    .max_idx(max_idx), .min_idx(min_idx),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: frame samples collected in a queue, result computed at close
  int  q[$];
  bit  m_hold;
  int  m_max, m_min, m_cnt, m_max_idx, m_min_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_hold = 0; m_max = 0; m_min = 0; m_cnt = 0; m_max_idx = 0; m_min_idx = 0;
    end else if (m_hold) begin
      if (out_ready) m_hold = 0;
    end else if (in_valid) begin
      q.push_back(int'(in_data));
      if (in_last || q.size() == FRAME_LEN) begin
        m_max = q[0]; m_min = q[0]; m_max_idx = 0; m_min_idx = 0;
        foreach (q[i]) begin
          if (q[i] > m_max) begin m_max = q[i]; m_max_idx = i; end
          if (q[i] < m_min) begin m_min = q[i]; m_min_idx = i; end
        end
        m_cnt  = q.size();
        m_hold = 1;
        q.delete();
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(!m_hold));
      chk("out_valid", 32'(out_valid), 32'(m_hold));
      chk("max", 32'(max), 32'(m_max));
      chk("min", 32'(min), 32'(m_min));
      chk("count", 32'(count), 32'(m_cnt));
`ifdef MINMAX_INDEX_EN
      chk("max_idx", 32'(max_idx), 32'(m_max_idx));
      chk("min_idx", 32'(min_idx), 32'(m_min_idx));
`endif
    end
  end

  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    int n;
    in_valid = 1'b1; in_data = d; in_last = last;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int emax, input int emin, input int ecnt,
                               input int emax_idx, input int emin_idx);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_max"}, 32'(max), 32'(emax));
    chk({tag, "_min"}, 32'(min), 32'(emin));
    chk({tag, "_count"}, 32'(count), 32'(ecnt));
`ifdef MINMAX_INDEX_EN
    chk({tag, "_max_idx"}, 32'(max_idx), 32'(emax_idx));
    chk({tag, "_min_idx"}, 32'(min_idx), 32'(emin_idx));
`else
    if (emax_idx < 0 || emin_idx < 0) chk({tag, "_idx_arg"}, 32'd1, 32'd0);
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int f1[8] = '{8, 12, 13, 10, 3, 15, 7, 9};
    int f6[8] = '{9, 2, 14, 7, 7, 1, 11, 5};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_max", 32'(max), 32'd0);
    chk("rst_min", 32'(min), 32'd0);
    chk("rst_count", 32'(count), 32'd0);

    // Full-length frame closes without in_last; result valid the cycle after 8th accept
    foreach (f1[i]) send(WIDTH'(f1[i]), 1'b0);
    chk("f1_latency", 32'(out_valid), 32'd1);
    expect_result("f1", 15, 3, 8, 5, 4);

    // Early close, then backpressure with a sample waiting
    send(4'd8, 1'b0);
    send(4'd12, 1'b1);
    in_valid = 1'b1; in_data = 4'd4;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_max", 32'(max), 32'd12);
    end
    expect_result("f2", 12, 8, 2, 1, 0);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    send(4'd2, 1'b1);
    expect_result("f3", 4, 2, 2, 0, 1);

    // Ties and extremes
    send(4'd0, 1'b0); send(4'd15, 1'b0); send(4'd15, 1'b0); send(4'd0, 1'b1);
    expect_result("f4", 15, 0, 4, 1, 0);
    chk("after_accept_max", 32'(max), 32'd15);

    // Reset mid-frame discards partial frame
    send(4'd13, 1'b0); send(4'd10, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    send(4'd5, 1'b0); send(4'd6, 1'b1);
    expect_result("f5", 6, 5, 2, 1, 0);

    // Gapped input with a stray in_last while in_valid is low
    foreach (f6[i]) begin
      send(WIDTH'(f6[i]), 1'b0);
      in_last = 1'b1;
      @(posedge clk); #1;
      in_last = 1'b0;
    end
    expect_result("f6", 14, 1, 8, 2, 5);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
